// File: rtl/instr_mem_loader_if.sv
// Handshake/memory-port bundle between a word source, instr_mem_loader and the instruction memory.
// The Checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W:0]   count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              fetch_hold;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    output start, count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, fetch_hold, checksum
  );
  modport slave (
    input  start, count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, fetch_hold, checksum
  );
`else
  modport master (
    output start, count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, fetch_hold
  );
  modport slave (
    input  start, count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, fetch_hold
  );
`endif
endinterface

// File: rtl/instr_mem_loader.sv
// Streams instruction words into consecutive memory addresses from 0 while holding fetch in reset.
// Optional running checksum of loaded words when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_mem_loader_if.slave   bus_io
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start_ok;
  logic              xfer;

  // Limiting the load to the memory depth keeps the address counter from wrapping.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus_io.start;
  assign xfer     = (state_q == S_LOAD) && bus_io.in_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (bus_io.count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            addr_d  = '0;
            rem_d   = clamp_count(bus_io.count);
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = bus_io.in_data;
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok)  sum_d = '0;
    else if (xfer) sum_d = sum_q + bus_io.in_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign bus_io.checksum = sum_q;
`endif

  assign bus_io.in_ready   = (state_q == S_LOAD);
  assign bus_io.busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign bus_io.fetch_hold = bus_io.busy;
  assign bus_io.done       = (state_q == S_DONE);
  assign bus_io.mem_we     = we_q;
  assign bus_io.mem_addr   = maddr_q;
  assign bus_io.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: per-cycle output expectations derived from each load plan,
// plus a memory scoreboard fed by observed write-port activity.
module tb_instr_mem_loader;

  logic clk;
  logic rst;

  instr_mem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_mem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          wcount = 0;
  logic [15:0] mem  [256];
  logic [15:0] plan [256];
  logic [7:0]  l_addr;
  logic [15:0] l_data;
  logic [15:0] e_sum;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Memory model: commits whatever the write port presents at each rising edge.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wcount <= wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic [8:0] cnt, input logic v, input logic [15:0] d);
    bus.start    = st;
    bus.count    = cnt;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input logic rdy, input logic bsy, input logic dn, input logic we);
    chk("in_ready",   32'(bus.in_ready),   32'(rdy));
    chk("busy",       32'(bus.busy),       32'(bsy));
    chk("fetch_hold", 32'(bus.fetch_hold), 32'(bsy));
    chk("done",       32'(bus.done),       32'(dn));
    chk("mem_we",     32'(bus.mem_we),     32'(we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(l_addr));
    chk("mem_wdata",  32'(bus.mem_wdata),  32'(l_data));
`ifdef LOADER_CHECKSUM_EN
    if (dn) chk("checksum", 32'(bus.checksum), 32'(e_sum));
`endif
  endtask

  task automatic run_load(input int n, input int gmin, input int gmax, input bit fill_rand);
    int eff;
    int w0;
    eff = (n > 256) ? 256 : n;
    w0  = wcount;
    if (fill_rand) for (int i = 0; i < eff; i++) plan[i] = 16'($urandom);
    e_sum = '0;
    step(1'b1, 9'(n), 1'($urandom_range(0, 1)), 16'($urandom));
    if (eff == 0) begin
      expect_out(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 9'd0, 1'b1, 16'($urandom));
      expect_out(1'b0, 1'b0, 1'b1, 1'b0);
      chk("writes_zero", 32'(wcount - w0), 32'd0);
      return;
    end
    expect_out(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < eff; i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 300)), 1'b0, 16'($urandom));
        expect_out(1'b1, 1'b1, 1'b0, 1'b0);
      end
      step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 300)), 1'b1, plan[i]);
      l_addr = i[7:0];
      l_data = plan[i];
      e_sum  = e_sum + plan[i];
      expect_out(i != eff - 1, 1'b1, 1'b0, 1'b1);
    end
    // FLUSH cycle: start and valid presented here must be ignored
    step(1'($urandom_range(0, 1)), 9'($urandom_range(1, 300)), 1'($urandom_range(0, 1)), 16'($urandom));
    expect_out(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 9'd0, 1'b1, 16'($urandom));
    expect_out(1'b0, 1'b0, 1'b1, 1'b0);
    chk("writes", 32'(wcount - w0), 32'(eff));
    for (int i = 0; i < eff; i++) chk("mem", 32'(mem[i]), 32'(plan[i]));
  endtask

  task automatic run_abort();
    int w0;
    w0 = wcount;
    for (int i = 0; i < 5; i++) plan[i] = 16'($urandom);
    e_sum = '0;
    step(1'b1, 9'd5, 1'b0, 16'd0);
    expect_out(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 9'd0, 1'b1, plan[i]);
      l_addr = i[7:0];
      l_data = plan[i];
      expect_out(1'b1, 1'b1, 1'b0, 1'b1);
    end
    rst = 1'b1;
    step(1'b0, 9'd0, 1'b1, plan[2]);
    rst = 1'b0;
    l_addr = '0;
    l_data = '0;
    expect_out(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 9'd0, 1'b1, plan[3]);
    expect_out(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_writes", 32'(wcount - w0), 32'd2);
    chk("abort_mem0", 32'(mem[0]), 32'(plan[0]));
    chk("abort_mem1", 32'(mem[1]), 32'(plan[1]));
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.count    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    l_addr       = '0;
    l_data       = '0;
    e_sum        = '0;
    @(negedge clk);
    step(1'b1, 9'd3, 1'b1, 16'h1234);
    step(1'b0, 9'd0, 1'b0, 16'h0);
    expect_out(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    plan[0] = 16'h1111;
    plan[1] = 16'h2222;
    plan[2] = 16'h3333;
    run_load(3, 0, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_directed", 32'(bus.checksum), 32'h6666);
`endif

    run_load(2, 2, 2, 1'b1);
    run_load(0, 0, 0, 1'b1);
    run_load(257, 0, 0, 1'b1);
    chk("full_last_addr", 32'(bus.mem_addr), 32'hFF);

    run_abort();
    run_load(4, 0, 1, 1'b1);

    for (int k = 0; k < 12; k++) begin
      int n;
      n = (k % 5 == 4) ? 0 : int'($urandom_range(40, 1));
      run_load(n, 0, 3, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side counterpart of the instruction fetch path: accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into consecutive instruction-memory addresses starting at 0. While a load is in progress it holds the fetch unit in reset, so the processor only begins fetching from a fully written program. It sits between the board-level data source (switch/button front end or serial receiver) and the instruction memory write port, beside the fetch unit in the top level.

## Interface
- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words
- DATA_W, 16, instruction word width
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- Start  in  1  begin a load; sampled only in IDLE or DONE
- Count  in  ADDR_W+1  number of words to load, sampled with Start
- InValid  in  1  source has a word on InData
- InData  in  DATA_W  instruction word
- InReady  out  1  loader accepts a word this cycle
- MemWe  out  1  instruction-memory write enable (registered)
- MemAddr  out  ADDR_W  write address (registered)
- MemWData  out  DATA_W  write data (registered)
- Busy  out  1  high in LOAD and FLUSH
- Done  out  1  high in DONE; held until next Start or Reset
- FetchHold  out  1  drive to fetch-unit reset; equals Busy
- Checksum  out  DATA_W  only with LOADER_CHECKSUM_EN

## Operation
- States: IDLE, LOAD, FLUSH, DONE. Reset → IDLE; all outputs 0, address counter 0, remaining counter 0.
- IDLE/DONE + Start: Count==0 → DONE (Done stays/becomes 1, no writes). Count>0 → LOAD; address counter ← 0; remaining ← min(Count, 2^ADDR_W); Done ← 0.
- LOAD: InReady=1. Transfer occurs on an edge with InValid&&InReady. Each transfer: MemWe←1, MemAddr←address counter, MemWData←InData; address counter +1; remaining −1. Edge without transfer: MemWe←0.
- Transfer with remaining==1 → FLUSH.
- FLUSH: InReady=0, one cycle; MemWe←0 at its end; → DONE.
- DONE: InReady=0, MemWe=0, Done=1, FetchHold=0. MemAddr/MemWData hold last written values.
- Start in LOAD/FLUSH ignored. InValid outside LOAD ignored (no transfer, InData not captured).
- Address counter is ADDR_W bits; Count clamp guarantees no wrap within one load (max write address 2^ADDR_W−1).
- Reset mid-load: immediate return to IDLE; words already written stay in memory; in-flight MemWe is dropped (no write at the Reset edge's following cycle).

## Timing
- Word transferred at edge k → MemWe=1, MemAddr/MemWData valid during cycle k..k+1; memory commits at edge k+1.
- Back-to-back transfers sustain 1 word/cycle; MemWe stays high continuously.
- Last transfer at edge k: state FLUSH during k..k+1 (InReady=0, MemWe=1); at edge k+1 → DONE, Done=1, Busy=FetchHold=0, MemWe=0.
- Start at edge s (Count>0): Busy=FetchHold=InReady=1 from edge s; earliest transfer at edge s+1.
- Start with Count==0 at edge s: Done=1 from edge s, Busy never rises.

## Configuration
- LOADER_CHECKSUM_EN defined: Checksum port present; register cleared on accepted Start, adds InData (mod 2^DATA_W) on each transfer; stable and valid while Done=1; reset value 0.
- Undefined: no Checksum port, no accumulator logic; all other behaviour identical.

## Test plan
- Reset then Start, Count=3, InValid held high with 0x1111,0x2222,0x3333 → writes addr 0,1,2 on three consecutive cycles; Done=1 two cycles after third transfer edge's preceding cycle (edge k+1); checksum 0x6666.
- Count=2 with InValid gapped (valid, 2 idle cycles, valid) → MemWe low during gap, exactly 2 writes at addr 0,1; FetchHold high throughout until FLUSH ends.
- Count=0 → Done=1 next cycle, no MemWe, InReady never high.
- Count=2^ADDR_W+1 (ADDR_W=8, Count=257) → exactly 256 writes, last at addr 0xFF, then DONE.
- Reset asserted after 2 of 5 transfers → all outputs 0 next cycle, state IDLE, no further MemWe; new Start reloads from addr 0.
- Start pulsed during LOAD, and InValid during DONE → ignored; write count and addresses unchanged.
